// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - one 256-bit cache line transfer as a 4-beat 64-bit memory burst
// Optional read-beat address check: define CACHELINE_ADAPTER_ADDR_CHECK_EN
module cacheline_adapter #(
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                line_addr,
    input  logic                       line_read,
    input  logic                       line_write,
    input  logic [BEAT_W*BEATS-1:0]    line_wdata,
    output logic [BEAT_W*BEATS-1:0]    line_rdata,
    output logic                       line_resp,
    output logic [31:0]                mem_addr,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [BEAT_W-1:0]          mem_wdata,
    input  logic                       mem_ready,
    input  logic [31:0]                mem_raddr,
    input  logic [BEAT_W-1:0]          mem_rdata,
    input  logic                       mem_rvalid,
    output logic                       err
);
    localparam int LINE_W = BEAT_W * BEATS;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int OFF_W  = $clog2(LINE_W / 8);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_BURST,
        RESP
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [31:0]        addr_q;
    logic               is_rd;
    logic [LINE_W-1:0]  line_buf;
    logic               addr_match;
    logic               beat_take;
    logic               last_beat;
    logic               unused_bits;

`ifdef CACHELINE_ADAPTER_ADDR_CHECK_EN
    // Only the line-number bits identify the beat's owner; the offset bits are free.
    assign addr_match  = (mem_raddr[31:OFF_W] == addr_q[31:OFF_W]);
    assign unused_bits = ^{line_addr[OFF_W-1:0], mem_raddr[OFF_W-1:0]};
`else
    assign addr_match  = 1'b1;
    assign unused_bits = ^{line_addr[OFF_W-1:0], mem_raddr};
`endif

    assign beat_take = (state == RD_DATA) && mem_rvalid && addr_match;
    assign last_beat = (cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            is_rd    <= 1'b0;
            line_buf <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && (line_write || line_read)) begin
                addr_q <= {line_addr[31:OFF_W], {OFF_W{1'b0}}};
                is_rd  <= !line_write;
            end
            if (beat_take) begin
                line_buf[BEAT_W*cnt +: BEAT_W] <= mem_rdata;
            end
        end
    end

`ifdef CACHELINE_ADAPTER_ADDR_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == RD_DATA && mem_rvalid && !addr_match) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        line_resp  = 1'b0;
        line_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                // Write wins a simultaneous request so the outcome is deterministic.
                if (line_write) begin
                    state_next = WR_BURST;
                    cnt_next   = '0;
                end else if (line_read) begin
                    state_next = RD_REQ;
                end
            end
            RD_REQ: begin
                mem_read = 1'b1;
                mem_addr = addr_q;
                if (mem_ready) begin
                    state_next = RD_DATA;
                    cnt_next   = '0;
                end
            end
            RD_DATA: begin
                if (beat_take) begin
                    cnt_next = CNT_W'(cnt + 1'b1);
                    if (last_beat) begin
                        state_next = RESP;
                    end
                end
            end
            WR_BURST: begin
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = line_wdata[BEAT_W*cnt +: BEAT_W];
                if (mem_ready) begin
                    cnt_next = CNT_W'(cnt + 1'b1);
                    if (last_beat) begin
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                line_resp  = 1'b1;
                line_rdata = is_rd ? line_buf : '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_cacheline_adapter.sv
// tb/tb_cacheline_adapter.sv - directed self-checking bench for cacheline_adapter
module tb_cacheline_adapter;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  line_addr;
    logic         line_read;
    logic         line_write;
    logic [255:0] line_wdata;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic [31:0]  mem_addr;
    logic         mem_read;
    logic         mem_write;
    logic [63:0]  mem_wdata;
    logic         mem_ready;
    logic [31:0]  mem_raddr;
    logic [63:0]  mem_rdata;
    logic         mem_rvalid;
    logic         err;

    int tests = 0;
    int fails = 0;

    cacheline_adapter dut (
        .clk        (clk),
        .rst        (rst),
        .line_addr  (line_addr),
        .line_read  (line_read),
        .line_write (line_write),
        .line_wdata (line_wdata),
        .line_rdata (line_rdata),
        .line_resp  (line_resp),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic feed_beats(input logic [31:0] base, input logic [63:0] b0, input logic [63:0] b1,
                              input logic [63:0] b2, input logic [63:0] b3, input int gap);
        logic [63:0] b [4];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = b[k];
            mem_raddr  = base + 32'(8 * k);
            tick;
            mem_rvalid = 1'b0;
            if (k < 3) begin
                for (int g = 0; g < gap; g++) tick;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        line_addr = '0; line_read = 1'b0; line_write = 1'b0; line_wdata = '0;
        mem_ready = 1'b0; mem_raddr = '0; mem_rdata = '0; mem_rvalid = 1'b0;
        tick;
        tick;
        tests++; if ({line_resp, mem_read, mem_write} !== 3'b000) begin fails++; $display("FAIL reset_ctrl: got %b exp 000", {line_resp, mem_read, mem_write}); end
        tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr: got %h exp 0", mem_addr); end
        tests++; if (mem_wdata !== 64'h0) begin fails++; $display("FAIL reset_mem_wdata: got %h exp 0", mem_wdata); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b exp 0", err); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_read;
        line_addr = 32'h0000_1234; line_read = 1'b1; mem_ready = 1'b1;
        tick;
        tests++; if (mem_read !== 1'b1) begin fails++; $display("FAIL rd_req_mem_read: got %b exp 1", mem_read); end
        tests++; if (mem_addr !== 32'h0000_1220) begin fails++; $display("FAIL rd_req_addr: got %h exp 00001220", mem_addr); end
        tick;
        tests++; if (mem_read !== 1'b0) begin fails++; $display("FAIL rd_req_one_cycle: got %b exp 0", mem_read); end
        feed_beats(32'h0000_1220, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                   64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 0);
        tests++; if (line_resp !== 1'b1) begin fails++; $display("FAIL rd_resp: got %b exp 1", line_resp); end
        tests++; if (line_rdata !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111})
            begin fails++; $display("FAIL rd_data: got %h", line_rdata); end
        line_read = 1'b0;
        tick;
        tests++; if (line_resp !== 1'b0) begin fails++; $display("FAIL rd_resp_pulse: got %b exp 0", line_resp); end
    endtask

    task automatic test_write_stall;
        line_addr  = 32'h0000_5678;
        line_wdata = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        line_write = 1'b1; mem_ready = 1'b1;
        tick;
        tests++; if (mem_write !== 1'b1 || mem_addr !== 32'h0000_5660) begin fails++; $display("FAIL wr_start: got write=%b addr=%h exp 1 00005660", mem_write, mem_addr); end
        tests++; if (mem_wdata !== 64'hAAAA_AAAA_AAAA_AAAA) begin fails++; $display("FAIL wr_beat0: got %h exp aaaa...", mem_wdata); end
        tick;
        mem_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            tests++; if (mem_wdata !== 64'hBBBB_BBBB_BBBB_BBBB || mem_write !== 1'b1 || mem_addr !== 32'h0000_5660)
                begin fails++; $display("FAIL wr_stall_hold%0d: got %h write=%b addr=%h exp bbbb... 1 00005660", s, mem_wdata, mem_write, mem_addr); end
            if (s < 3) tick;
        end
        mem_ready = 1'b1;
        tick;
        tests++; if (mem_wdata !== 64'hCCCC_CCCC_CCCC_CCCC) begin fails++; $display("FAIL wr_beat2: got %h exp cccc...", mem_wdata); end
        tick;
        tests++; if (mem_wdata !== 64'hDDDD_DDDD_DDDD_DDDD || line_resp !== 1'b0) begin fails++; $display("FAIL wr_beat3: got %h resp=%b exp dddd... 0", mem_wdata, line_resp); end
        tick;
        tests++; if (line_resp !== 1'b1 || mem_write !== 1'b0 || line_rdata !== 256'h0)
            begin fails++; $display("FAIL wr_resp: got resp=%b write=%b rdata=%h exp 1 0 0", line_resp, mem_write, line_rdata); end
        line_write = 1'b0;
        tick;
        tests++; if (line_resp !== 1'b0) begin fails++; $display("FAIL wr_resp_pulse: got %b exp 0", line_resp); end
    endtask

    task automatic test_back_to_back;
        line_addr  = 32'h0000_0100;
        line_wdata = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303, 64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
        line_write = 1'b1; mem_ready = 1'b1;
        tick;
        tests++; if (mem_addr !== 32'h0000_0100 || mem_wdata !== 64'h0101_0101_0101_0101)
            begin fails++; $display("FAIL b2b_wr_beat0: got addr=%h data=%h exp 00000100 0101...", mem_addr, mem_wdata); end
        tick; tick; tick;
        tests++; if (mem_wdata !== 64'h0404_0404_0404_0404) begin fails++; $display("FAIL b2b_wr_beat3: got %h exp 0404...", mem_wdata); end
        tick;
        tests++; if (line_resp !== 1'b1) begin fails++; $display("FAIL b2b_wr_resp: got %b exp 1", line_resp); end
        line_write = 1'b0;
        tick;
        line_addr = 32'h0000_2040; line_read = 1'b1;
        tick;
        tests++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h0000_2040)
            begin fails++; $display("FAIL b2b_rd_req: got read=%b write=%b addr=%h exp 1 0 00002040", mem_read, mem_write, mem_addr); end
        tick;
        feed_beats(32'h0000_2040, 64'h0A0A_0A0A_0A0A_0A0A, 64'h0B0B_0B0B_0B0B_0B0B,
                   64'h0C0C_0C0C_0C0C_0C0C, 64'h0D0D_0D0D_0D0D_0D0D, 0);
        tests++; if (line_resp !== 1'b1 || line_rdata !== {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C, 64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A})
            begin fails++; $display("FAIL b2b_rd_data: got resp=%b rdata=%h", line_resp, line_rdata); end
        line_read = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_burst;
        line_addr = 32'h0000_3000; line_read = 1'b1; mem_ready = 1'b1;
        tick;
        tick;
        mem_rvalid = 1'b1; mem_raddr = 32'h0000_3000; mem_rdata = 64'hE0E0_E0E0_E0E0_E0E0;
        tick;
        mem_rdata = 64'hE1E1_E1E1_E1E1_E1E1; mem_raddr = 32'h0000_3008;
        tick;
        mem_rdata = 64'hE2E2_E2E2_E2E2_E2E2;
        rst = 1'b1;
        tick;
        tests++; if ({line_resp, mem_read, mem_write} !== 3'b000 || mem_addr !== 32'h0 || mem_wdata !== 64'h0)
            begin fails++; $display("FAIL rst_mid_outputs: got ctrl=%b addr=%h wdata=%h exp 0", {line_resp, mem_read, mem_write}, mem_addr, mem_wdata); end
        mem_rvalid = 1'b0;
        rst = 1'b0;
        line_addr = 32'h0000_3100;
        tick;
        tests++; if (mem_read !== 1'b1 || mem_addr !== 32'h0000_3100 || line_resp !== 1'b0)
            begin fails++; $display("FAIL rst_mid_new_req: got read=%b addr=%h resp=%b exp 1 00003100 0", mem_read, mem_addr, line_resp); end
        tick;
        feed_beats(32'h0000_3100, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                   64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888, 0);
        tests++; if (line_resp !== 1'b1 || line_rdata !== {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555})
            begin fails++; $display("FAIL rst_mid_new_data: got resp=%b rdata=%h", line_resp, line_rdata); end
        line_read = 1'b0;
        tick;
    endtask

    task automatic test_gaps;
        mem_rvalid = 1'b1; mem_raddr = 32'h0000_4000; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        tick;
        mem_rvalid = 1'b0;
        tests++; if (line_resp !== 1'b0 || mem_read !== 1'b0) begin fails++; $display("FAIL idle_rvalid: got resp=%b read=%b exp 0 0", line_resp, mem_read); end
        line_addr = 32'h0000_401F; line_read = 1'b1;
        tick;
        tests++; if (mem_addr !== 32'h0000_4000) begin fails++; $display("FAIL gap_addr: got %h exp 00004000", mem_addr); end
        tick;
        feed_beats(32'h0000_4000, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                   64'h0F0F_0F0F_F0F0_F0F0, 64'h1357_9BDF_2468_ACE0, 2);
        tests++; if (line_resp !== 1'b1 || line_rdata !== {64'h1357_9BDF_2468_ACE0, 64'h0F0F_0F0F_F0F0_F0F0, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF})
            begin fails++; $display("FAIL gap_data: got resp=%b rdata=%h", line_resp, line_rdata); end
        line_read = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'hBEEF_BEEF_BEEF_BEEF;
        tick;
        tick;
        mem_rvalid = 1'b0;
        tests++; if (line_resp !== 1'b0 || mem_read !== 1'b0) begin fails++; $display("FAIL extra_rvalid: got resp=%b read=%b exp 0 0", line_resp, mem_read); end
    endtask

    task automatic test_addr_check;
        logic [31:0]  ra [5];
        logic [63:0]  rd [5];
        logic [255:0] exp_data;
        int           exp_beats;
        int           seen;
        logic         exp_err;
        ra[0] = 32'h0000_6000; rd[0] = 64'hA0A0_A0A0_A0A0_A0A0;
        ra[1] = 32'h0000_7000; rd[1] = 64'h0BAD_0BAD_0BAD_0BAD;
        ra[2] = 32'h0000_6008; rd[2] = 64'hA1A1_A1A1_A1A1_A1A1;
        ra[3] = 32'h0000_6010; rd[3] = 64'hA2A2_A2A2_A2A2_A2A2;
        ra[4] = 32'h0000_6018; rd[4] = 64'hA3A3_A3A3_A3A3_A3A3;
`ifdef CACHELINE_ADAPTER_ADDR_CHECK_EN
        exp_beats = 5; exp_err = 1'b1;
        exp_data  = {rd[4], rd[3], rd[2], rd[0]};
`else
        exp_beats = 4; exp_err = 1'b0;
        exp_data  = {rd[3], rd[2], rd[1], rd[0]};
`endif
        line_addr = 32'h0000_6000; line_read = 1'b1; mem_ready = 1'b1;
        tick;
        tick;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            mem_rvalid = 1'b1; mem_raddr = ra[i]; mem_rdata = rd[i];
            tick;
            if (i == 1) begin
                tests++; if (err !== exp_err) begin fails++; $display("FAIL chk_err_set: got %b exp %b", err, exp_err); end
            end
            if (line_resp === 1'b1) begin
                seen = i + 1;
                break;
            end
        end
        mem_rvalid = 1'b0;
        tests++; if (seen !== exp_beats) begin fails++; $display("FAIL chk_beats_to_resp: got %0d exp %0d", seen, exp_beats); end
        tests++; if (line_rdata !== exp_data) begin fails++; $display("FAIL chk_data: got %h exp %h", line_rdata, exp_data); end
        line_read = 1'b0;
        tick;
        tick;
        tests++; if (err !== exp_err) begin fails++; $display("FAIL chk_err_sticky: got %b exp %b", err, exp_err); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL chk_err_cleared: got %b exp 0", err); end
    endtask

    initial begin
        test_reset;
        test_read;
        test_write_stall;
        test_back_to_back;
        test_reset_mid_burst;
        test_gaps;
        test_addr_check;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
